// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, writeback selects, and the payload
// stored by the ALU output stage.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [4:0] C_ADD_U = 5'h00;
  localparam logic [4:0] C_SUB_U = 5'h01;
  localparam logic [4:0] C_MUL_U = 5'h02;
  localparam logic [4:0] C_MUL_S = 5'h03;
  localparam logic [4:0] C_ADD_S = 5'h04;
  localparam logic [4:0] C_SUB_S = 5'h05;
  localparam logic [4:0] C_AND   = 5'h06;
  localparam logic [4:0] C_OR    = 5'h07;
  localparam logic [4:0] C_XOR   = 5'h08;
  localparam logic [4:0] C_NOR   = 5'h09;
  localparam logic [4:0] C_SLT   = 5'h0A;
  localparam logic [4:0] C_SLTU  = 5'h0B;
  localparam logic [4:0] C_SLL   = 5'h0C;
  localparam logic [4:0] C_SRL   = 5'h0D;
  localparam logic [4:0] C_SRA   = 5'h0E;
  localparam logic [4:0] C_LUI   = 5'h0F;

  localparam logic [1:0] C_SEL_RESULT = 2'd0;
  localparam logic [1:0] C_SEL_LO     = 2'd1;
  localparam logic [1:0] C_SEL_HI     = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              branch;
  } alu_out_entry_t;

  // Any code outside the multiply pair, including unassigned ones, is non-multiply.
  function automatic logic is_mul_op(input logic [4:0] opsel);
    case (opsel)
      C_MUL_U, C_MUL_S: is_mul_op = 1'b1;
      default:          is_mul_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_out_stage_if.sv
// ALU-to-stage payload handshake and stage-to-writeback handshake.
// master is the side feeding the ALU payload and consuming the output.
interface alu_out_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [WIDTH-1:0] in_result_hi;
  logic             in_branch_taken;
  logic [4:0]       in_opsel;
  logic [1:0]       in_lo_hi_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_branch;

  modport master (
    output in_valid, in_result, in_result_hi, in_branch_taken, in_opsel, in_lo_hi_sel,
    output out_ready,
    input  in_ready, out_valid, out_data, out_branch
  );

  modport slave (
    input  in_valid, in_result, in_result_hi, in_branch_taken, in_opsel, in_lo_hi_sel,
    input  out_ready,
    output in_ready, out_valid, out_data, out_branch
  );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: main entry drives the outputs, skid entry
// absorbs one extra payload so in_ready can come straight from a register.
module skid_buffer #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T     main_r;
  T     skid_r;
  logic main_valid_r;
  logic skid_full_r;
  logic accept_s;
  logic emit_s;
  logic main_free_s;

  // flush gates acceptance so a same-cycle input is never half-taken
  assign in_ready    = !skid_full_r && !flush;
  assign accept_s    = in_valid && in_ready;
  assign emit_s      = main_valid_r && out_ready;
  assign main_free_s = !main_valid_r || emit_s;

  // Main/skid entry storage; skid drains into main before any new input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_full_r  <= 1'b0;
    end else if (flush) begin
      main_valid_r <= 1'b0;
      skid_full_r  <= 1'b0;
    end else if (main_free_s) begin
      if (skid_full_r) begin
        main_r       <= skid_r;
        main_valid_r <= 1'b1;
        skid_full_r  <= 1'b0;
      end else if (accept_s) begin
        main_r       <= in_data;
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      skid_r      <= in_data;
      skid_full_r <= 1'b1;
    end
  end

  assign out_valid = main_valid_r;
  assign out_data  = main_r;

endmodule

// File: rtl/alu_out_stage.sv
// Registered stage after the ALU: maintains LO/HI, selects the writeback value
// at accept time and queues it through a two-entry skid buffer.
module alu_out_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  alu_out_stage_if.slave   bus,
  output logic [WIDTH-1:0] lo_q,
  output logic [WIDTH-1:0] hi_q
);

  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] sel_data_s;
  logic             accept_s;
  alu_out_entry_t   in_entry_s;
  alu_out_entry_t   out_entry_s;

  assign accept_s = bus.in_valid && bus.in_ready;

  // Writeback select uses LO/HI as held before this payload's own write
  always_comb begin
    sel_data_s = bus.in_result;
    case (bus.in_lo_hi_sel)
      C_SEL_LO: sel_data_s = lo_r;
      C_SEL_HI: sel_data_s = hi_r;
      default:  sel_data_s = bus.in_result;
    endcase
  end

  // Pack the selected value and branch outcome into one buffer entry
  always_comb begin
    in_entry_s        = '0;
    in_entry_s.data   = sel_data_s;
    in_entry_s.branch = bus.in_branch_taken;
  end

  // LO/HI follow every accepted multiply regardless of downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_r <= '0;
      hi_r <= '0;
    end else if (accept_s && is_mul_op(bus.in_opsel)) begin
      lo_r <= bus.in_result;
      hi_r <= bus.in_result_hi;
    end
  end

  skid_buffer #(
    .T(alu_out_entry_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry_s),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_entry_s)
  );

  assign bus.out_data   = out_entry_s.data;
  assign bus.out_branch = out_entry_s.branch;
  assign lo_q           = lo_r;
  assign hi_q           = hi_r;

endmodule

// File: tb/tb_alu_out_stage.sv
// Scoreboard bench for alu_out_stage: directed scenarios plus random traffic,
// checked against a queue-based model of the stage's FIFO and LO/HI rules.
module tb_alu_out_stage;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [W-1:0] lo_q;
  logic [W-1:0] hi_q;

  alu_out_stage_if #(.WIDTH(W)) bus ();

  alu_out_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .lo_q  (lo_q),
    .hi_q  (hi_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         branch;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] lo_m = '0;
  logic [W-1:0] hi_m = '0;
  int           total = 0;
  int           bad = 0;

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Monitor: sample at the falling edge what the next rising edge will do.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb_q.delete();
      lo_m = '0;
      hi_m = '0;
    end else begin
      check_b("in_ready", bus.in_ready, (sb_q.size() < 2) && !flush);
      check_b("out_valid", bus.out_valid, sb_q.size() != 0);
      check_w("lo_q", lo_q, lo_m);
      check_w("hi_q", hi_q, hi_m);
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check_b("unexpected_output", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check_w("out_data", bus.out_data, e.data);
          check_b("out_branch", bus.out_branch, e.branch);
        end
      end
      if (flush) begin
        sb_q.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        case (bus.in_lo_hi_sel)
          2'd1:    e.data = lo_m;
          2'd2:    e.data = hi_m;
          default: e.data = bus.in_result;
        endcase
        e.branch = bus.in_branch_taken;
        sb_q.push_back(e);
        if (bus.in_opsel == C_MUL_U || bus.in_opsel == C_MUL_S) begin
          lo_m = bus.in_result;
          hi_m = bus.in_result_hi;
        end
      end
    end
  end

  // Present a payload and hold it until it is accepted (bounded wait).
  task automatic send(input logic [W-1:0] res, input logic [W-1:0] hi, input logic br,
                      input logic [4:0] op, input logic [1:0] sel);
    bit ok;
    ok = 1'b0;
    bus.in_valid        = 1'b1;
    bus.in_result       = res;
    bus.in_result_hi    = hi;
    bus.in_branch_taken = br;
    bus.in_opsel        = op;
    bus.in_lo_hi_sel    = sel;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_b("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid        = 1'b0;
    bus.in_result       = '0;
    bus.in_result_hi    = '0;
    bus.in_branch_taken = 1'b0;
    bus.in_opsel        = 5'd0;
    bus.in_lo_hi_sel    = 2'd0;
    bus.out_ready       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_b("rst_out_valid", bus.out_valid, 1'b0);
    check_w("rst_out_data", bus.out_data, 32'h0);
    check_b("rst_out_branch", bus.out_branch, 1'b0);
    check_b("rst_in_ready", bus.in_ready, 1'b1);
    check_w("rst_lo", lo_q, 32'h0);
    check_w("rst_hi", hi_q, 32'h0);
    rst = 1'b0;

    // Single ADD: visible on the cycle after accept
    bus.out_ready = 1'b1;
    send(32'h0000_0005, 32'h0, 1'b1, C_ADD_U, C_SEL_RESULT);
    check_b("lat_out_valid", bus.out_valid, 1'b1);
    check_w("lat_out_data", bus.out_data, 32'h0000_0005);
    check_w("lat_lo", lo_q, 32'h0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Multiply followed by MFLO / MFHI back-to-back
    send(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, C_MUL_U, C_SEL_RESULT);
    send(32'h1111_1111, 32'h0, 1'b0, C_ADD_U, C_SEL_LO);
    send(32'h2222_2222, 32'h0, 1'b0, C_ADD_U, C_SEL_HI);
    bus.in_valid = 1'b0;
    check_w("mul_lo", lo_q, 32'hFFFF_FFFE);
    check_w("mul_hi", hi_q, 32'h0000_0001);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: A and B fill the buffer, C waits for release
    bus.out_ready = 1'b0;
    send(32'hAAAA_0001, 32'h0, 1'b1, C_SUB_U, C_SEL_RESULT);
    send(32'hBBBB_0002, 32'h0, 1'b0, C_ADD_U, C_SEL_RESULT);
    check_b("full_in_ready", bus.in_ready, 1'b0);
    fork
      send(32'hCCCC_0003, 32'h0, 1'b1, C_ADD_U, C_SEL_RESULT);
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Multiply while stalled still updates LO/HI
    bus.out_ready = 1'b0;
    send(32'h0000_0042, 32'h0, 1'b0, C_ADD_U, C_SEL_RESULT);
    send(32'h0000_1234, 32'h0000_ABCD, 1'b0, C_MUL_S, C_SEL_LO);
    bus.in_valid = 1'b0;
    check_w("stall_mul_lo", lo_q, 32'h0000_1234);
    check_w("stall_mul_hi", hi_q, 32'h0000_ABCD);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Flush with a full buffer and a same-cycle input
    bus.out_ready = 1'b0;
    send(32'h0000_0101, 32'h0, 1'b0, C_ADD_U, C_SEL_RESULT);
    send(32'h0000_0202, 32'h0, 1'b0, C_ADD_U, C_SEL_RESULT);
    flush = 1'b1;
    bus.in_result = 32'h0000_0303;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check_b("flush_out_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    check_b("flush_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset between edges
    send(32'h0000_0055, 32'h0000_0066, 1'b0, C_MUL_U, C_SEL_RESULT);
    send(32'h0000_0077, 32'h0, 1'b1, C_ADD_U, C_SEL_RESULT);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_b("arst_out_valid", bus.out_valid, 1'b0);
    check_w("arst_lo", lo_q, 32'h0);
    check_w("arst_hi", hi_q, 32'h0);
    check_b("arst_in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'h0000_0099, 32'h0, 1'b1, C_ADD_S, C_SEL_RESULT);
    bus.in_valid = 1'b0;
    check_b("post_rst_valid", bus.out_valid, 1'b1);
    check_w("post_rst_data", bus.out_data, 32'h0000_0099);
    repeat (2) @(posedge clk);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid        = ($urandom_range(0, 3) != 0);
      bus.in_result       = $urandom;
      bus.in_result_hi    = $urandom;
      bus.in_branch_taken = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        bus.in_opsel = ($urandom_range(0, 1) == 0) ? C_MUL_U : C_MUL_S;
      else
        bus.in_opsel = 5'($urandom_range(0, 31));
      bus.in_lo_hi_sel = 2'($urandom_range(0, 3));
      bus.out_ready    = ($urandom_range(0, 2) != 0);
      flush            = ($urandom_range(0, 31) == 0);
    end

    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    check_w("drain_empty", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
